// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline types and defaults for the fetch stage
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register, priority flush > stall > write
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        wr_en,
  input  fetch_pkt_t  wr_pkt,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= NOP_INSTR;
      pc    <= 32'h0;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!stall) begin
      if (wr_en) begin
        instr <= wr_pkt.instr;
        pc    <= wr_pkt.pc;
        pc4   <= wr_pkt.pc4;
        valid <= 1'b1;
      end else begin
        // nothing new arrived: decode sees a bubble rather than a repeat
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, request FSM, one-entry skid buffer, IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdata,
  input  logic        IMemValid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_e state, state_n;
  logic [31:0]  pcf, pcf_n;
  logic [31:0]  req_addr, req_addr_n;
  fetch_pkt_t   hold_pkt, hold_pkt_n;
  fetch_pkt_t   ifid_pkt;
  fetch_pkt_t   fetched;
  logic         ifid_wr;
  logic [31:0]  redirect;

  assign IMemReq  = (state != HOLD);
  assign IMemAddr = req_addr;
  assign redirect = word_align(PCTargetE);
  assign fetched  = '{instr: IMemRdata, pc: pcf, pc4: pc_plus4(pcf)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pcf      <= RESET_PC;
      req_addr <= RESET_PC;
      hold_pkt <= '0;
    end else begin
      state    <= state_n;
      pcf      <= pcf_n;
      req_addr <= req_addr_n;
      hold_pkt <= hold_pkt_n;
    end
  end

  always_comb begin
    state_n    = state;
    pcf_n      = pcf;
    hold_pkt_n = hold_pkt;
    ifid_wr    = 1'b0;
    ifid_pkt   = hold_pkt;

    case (state)
      FETCH: begin
        if (PCSrcE) begin
          pcf_n      = redirect;
          hold_pkt_n = '0;
          state_n    = IMemValid ? FETCH : DISCARD;
        end else if (IMemValid) begin
          pcf_n = pc_plus4(pcf);
          // a flushed cycle cannot take the word, so park it like a stall
          if (StallD || FlushD) begin
            hold_pkt_n = fetched;
            state_n    = HOLD;
          end else begin
            ifid_wr  = 1'b1;
            ifid_pkt = fetched;
          end
        end
      end

      HOLD: begin
        if (PCSrcE) begin
          pcf_n      = redirect;
          hold_pkt_n = '0;
          state_n    = FETCH;
        end else if (!StallD && !FlushD) begin
          ifid_wr  = 1'b1;
          state_n  = FETCH;
        end
      end

      DISCARD: begin
        if (PCSrcE) begin
          pcf_n = redirect;
        end
        if (IMemValid) begin
          state_n = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase

    // the outstanding request address is frozen until its response returns
    req_addr_n = (IMemReq && !IMemValid) ? req_addr : pcf_n;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .stall  (StallD),
    .flush  (FlushD),
    .wr_en  (ifid_wr),
    .wr_pkt (ifid_pkt),
    .instr  (InstrD),
    .pc     (PCD),
    .pc4    (PCPlus4D),
    .valid  (ValidD)
  );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 StallD  input  1  hold the IF/ID register and the PC.
REQ-007 FlushD  input  1  load a bubble into IF/ID.
REQ-008 PCSrcE  input  1  redirect fetch to PCTargetE.
REQ-009 PCTargetE  input  32  redirect target.
REQ-010 IMemReq  output  1  instruction-memory request valid.
REQ-011 IMemAddr  output  32  request address, word aligned.
REQ-012 IMemRdata  input  32  returned instruction word.
REQ-013 IMemValid  input  1  IMemRdata valid this cycle; may arrive the same cycle as the request or any number of cycles later.
REQ-014 InstrD  output  32  decode-stage instruction, consumed by the immediate extender and decoder.
REQ-015 PCD  output  32  PC of InstrD.
REQ-016 PCPlus4D  output  32  PCD+4.
REQ-017 ValidD  output  1  InstrD is a real instruction.

Function
REQ-018 The FSM SHALL have three states: FETCH, HOLD and DISCARD.
REQ-019 IMemReq SHALL be 1 in FETCH and DISCARD, and 0 in HOLD.
REQ-020 IMemAddr SHALL come from a request-address register and stay stable while IMemReq=1 until IMemValid.
REQ-021 In FETCH, on IMemValid with StallD=0 and PCSrcE=0, the block SHALL write IF/ID <= {IMemRdata, PCF, PCF+4}, set ValidD=1 and set PCF <= PCF+4.
REQ-022 In FETCH, on IMemValid with StallD=1 and PCSrcE=0, the block SHALL write the word, PC and PC+4 into a one-entry buffer, set PCF <= PCF+4 and move to HOLD.
REQ-023 In HOLD, when StallD=0, the block SHALL move the buffer into IF/ID, set ValidD=1 and return to FETCH.
REQ-024 PCSrcE=1 SHALL set PCF <= {PCTargetE[31:2],2'b00} and discard any buffered word.
REQ-025 On PCSrcE=1 in FETCH with no IMemValid, the next state SHALL be DISCARD.
REQ-026 On PCSrcE=1 in HOLD or with a same-cycle IMemValid, the next state SHALL be FETCH and the response is dropped.
REQ-027 In DISCARD, the block SHALL keep the old request address; on IMemValid it SHALL drop the data, write nothing to IF/ID and go to FETCH at the new PCF.
REQ-028 A second PCSrcE while in DISCARD SHALL update PCF only.
REQ-029 PCSrcE SHALL NOT modify IF/ID; squashing IF/ID is done only by FlushD.
REQ-030 FlushD=1 SHALL load InstrD=NOP_INSTR and ValidD=0, with PCD and PCPlus4D unchanged.
REQ-031 FlushD SHALL win over StallD and over a same-cycle IF/ID write; a word being captured that cycle goes to the buffer (HOLD) unless PCSrcE is also 1.
REQ-032 With StallD=1, IF/ID SHALL hold all values.
REQ-033 PC increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0.
REQ-034 The datapath SHALL have no combinational path from IMemRdata to InstrD; IF/ID latency is 1 cycle after IMemValid.

Reset
REQ-035 While rst=0: state=FETCH, PCF and request address=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, buffer empty.
REQ-036 The first request after reset SHALL be IMemReq=1, IMemAddr=RESET_PC in the first cycle after rst rises.
REQ-037 Reset asserted mid-request SHALL abandon the request; a late IMemValid after reset SHALL be accepted as the response to RESET_PC.

Structure
REQ-038 The FSM state encoding, NOP_INSTR and RESET_PC defaults SHALL live in the shared pipeline package.
REQ-039 The IF/ID register (stall/flush/write priority) SHALL be one sub-module, if_id_reg; the FSM, PC and buffer stay in fetch_stage.

Verification
REQ-040 Reset release, IMemValid same-cycle with fixed word 32'h00500093 -> InstrD=32'h00500093, PCD=0, PCPlus4D=4, ValidD=1; next IMemAddr=4.
REQ-041 StallD=1 for 3 cycles while a response arrives at PC 8 -> IMemReq=0 during HOLD, InstrD unchanged; on StallD=0, InstrD=word@8, PCD=8, next IMemAddr=12.
REQ-042 PCSrcE=1, PCTargetE=32'h40 while the request at 16 is pending, response 2 cycles later -> response dropped, IMemAddr=16 held until IMemValid, then IMemAddr=32'h40.
REQ-043 FlushD=1 and StallD=1 together -> InstrD=32'h00000013, ValidD=0.
REQ-044 RESET_PC=32'hFFFF_FFFC, one fetch -> PCPlus4D=0, next IMemAddr=0.
REQ-045 PCTargetE=32'h0000_0103 -> next IMemAddr=32'h0000_0100.
